// File: rtl/fix_div_seq.sv
// Sequential signed fixed-point divider: restoring shift-subtract, one quotient bit per clock.
// Start/done handshake, saturation on overflow, divide-by-zero flag.
`timescale 1ns/1ps
module fix_div_seq #(
  parameter int ws = 16,
  parameter int dp = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [ws-1:0] a,
  input  logic [ws-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [ws-1:0] c,
  output logic          dz,
  output logic          ovf
);

  localparam int N  = ws + dp;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  QPOS = (N'(1) << (ws - 1)) - N'(1);
  localparam logic [N-1:0]  QNEG = N'(1) << (ws - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            sign;
  logic [ws-1:0]   mag_b;
  logic [N-1:0]    dvd;
  logic [ws:0]     rem;
  logic [N-1:0]    quo;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            b_zero;
  logic            cnt_last;
  logic [ws-1:0]   abs_a, abs_b;
  logic [ws:0]     r_shift, r_next;
  logic            r_ge;
  logic [N-1:0]    q_next;
  logic [ws-1:0]   res;
  logic            res_ovf;

  assign accept   = start && (state != RUN);
  assign b_zero   = (b == '0);
  assign cnt_last = (cnt == CW'(1));
  assign abs_a    = a[ws-1] ? -a : a;
  assign abs_b    = b[ws-1] ? -b : b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = b_zero ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_next = b_zero ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One restoring step; the remainder stays below |b| so ws+1 bits never overflow.
  always_comb begin
    r_shift = (rem << 1) | (ws+1)'(dvd[N-1]);
    r_ge    = (r_shift >= {1'b0, mag_b});
    r_next  = r_ge ? (r_shift - {1'b0, mag_b}) : r_shift;
    q_next  = (quo << 1) | N'(r_ge);
    res     = sign ? -q_next[ws-1:0] : q_next[ws-1:0];
    res_ovf = 1'b0;
    if (!sign && (q_next > QPOS)) begin
      res     = QPOS[ws-1:0];
      res_ovf = 1'b1;
    end else if (sign && (q_next > QNEG)) begin
      res     = QNEG[ws-1:0];
      res_ovf = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign  <= 1'b0;
      mag_b <= '0;
      dvd   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      c     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      sign  <= a[ws-1] ^ b[ws-1];
      mag_b <= abs_b;
      dvd   <= N'(abs_a) << dp;
      rem   <= '0;
      quo   <= '0;
      cnt   <= CNT_INIT;
      dz    <= b_zero;
      ovf   <= 1'b0;
      if (b_zero) c <= a[ws-1] ? QNEG[ws-1:0] : QPOS[ws-1:0];
    end else if (state == RUN) begin
      rem <= r_next;
      quo <= q_next;
      dvd <= dvd << 1;
      cnt <= cnt - CW'(1);
      if (cnt_last) begin
        c   <= res;
        ovf <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fix_div_seq.sv
// Self-checking bench for fix_div_seq: directed cases plus random operands
// compared against a plain-integer fixed-point division model.
`timescale 1ns/1ps
module tb_fix_div_seq;

  localparam int WS  = 16;
  localparam int DP  = 8;
  localparam int LAT = WS + DP + 1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [WS-1:0] a, b;
  logic          busy, done, dz, ovf;
  logic [WS-1:0] c;

  int checks = 0;
  int errors = 0;

  fix_div_seq #(.ws(WS), .dp(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        dz;
    logic        ovf;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Signed value * 2^dp / divisor, truncated toward zero, then saturated.
  function automatic void model(input logic [15:0] ta, input logic [15:0] tb_,
                                output logic [15:0] ec, output logic edz, output logic eovf);
    longint av, bv, q;
    av   = longint'($signed(ta));
    bv   = longint'($signed(tb_));
    edz  = 1'b0;
    eovf = 1'b0;
    if (bv == 0) begin
      edz = 1'b1;
      ec  = (av >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      q = (av * (longint'(1) << DP)) / bv;
      if (q > 32767)       begin ec = 16'h7FFF; eovf = 1'b1; end
      else if (q < -32768) begin ec = 16'h8000; eovf = 1'b1; end
      else                 ec = 16'(q);
    end
  endfunction

  // Called away from a clock edge; returns #1 after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles to done (1 = first cycle after accept) and checks the result.
  task automatic wait_done(input string tag, input vec_t v, input int inject);
    int lat;
    bit busy_ok;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == inject) begin
        start = 1'b1;
        a     = ~v.a;
        b     = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "/latency"}, lat, v.dz ? 1 : LAT);
    check({tag, "/busy_run"}, busy_ok, 1);
    check({tag, "/busy_done"}, busy, 0);
    check({tag, "/c"}, c, v.c);
    check({tag, "/dz"}, dz, v.dz);
    check({tag, "/ovf"}, ovf, v.ovf);
  endtask

  task automatic do_op(input string tag, input vec_t v, input int inject);
    @(negedge clk);
    start_op(v.a, v.b);
    wait_done(tag, v, inject);
    @(posedge clk);
    #1;
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/c_hold"}, c, v.c);
  endtask

  vec_t dir[9];
  vec_t v, v2;
  bit   done_seen;

  initial begin
    dir[0] = '{16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0};
    dir[1] = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    dir[2] = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0};
    dir[3] = '{16'hFFFF, 16'h0200, 16'h0000, 1'b0, 1'b0};
    dir[4] = '{16'h7F00, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    dir[5] = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1};
    dir[6] = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
    dir[7] = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b0};
    dir[8] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/c", c, 0);
    check("reset/dz", dz, 0);
    check("reset/ovf", ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_op($sformatf("dir%0d", i), dir[i], 0);

    // start during RUN must not disturb the operation in flight
    do_op("ignore_start", dir[0], 5);

    // back-to-back: second start issued in the DONE cycle
    @(negedge clk);
    start_op(dir[1].a, dir[1].b);
    wait_done("b2b_first", dir[1], 0);
    start_op(dir[2].a, dir[2].b);
    wait_done("b2b_second", dir[2], 0);
    start_op(dir[7].a, dir[7].b);
    wait_done("b2b_dz", dir[7], 0);
    start_op(dir[0].a, dir[0].b);
    wait_done("b2b_after_dz", dir[0], 0);

    for (int i = 0; i < 40; i++) begin
      v.a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       v.b = 16'($urandom_range(0, 3));
        1:       v.b = {{8{v.a[0]}}, 8'($urandom)};
        default: v.b = 16'($urandom);
      endcase
      model(v.a, v.b, v.c, v.dz, v.ovf);
      do_op($sformatf("rand%0d_%h_%h", i, v.a, v.b), v, 0);
    end

    // reset mid-RUN aborts; c (non-zero from the previous op) must clear
    v2 = dir[4];
    do_op("pre_abort", v2, 0);
    @(negedge clk);
    start_op(dir[0].a, dir[0].b);
    repeat (8) @(posedge clk);
    #1;
    check("abort/busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort/busy", busy, 0);
    check("abort/done", done, 0);
    check("abort/c", c, 0);
    check("abort/dz", dz, 0);
    check("abort/ovf", ovf, 0);
    done_seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1'b1;
    end
    check("abort/no_done", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
